vdp_mac_sequencer: RTL
======================

// Module: vdp_mac_sequencer
// PURPOSE
//  Sequences one signed multiply-accumulate datapath through K-element vector dot products.
//  Accepts a stream of (g,e) operand pairs via valid/ready and accumulates exactly K products per vector.
//  Presents each finished dot product on a valid/ready output and restarts cleanly for the next vector.
//  Sits between the operand source (garbler/evaluator input streams) and the result consumer in the vdp benchmark.
// PARAMETERS
//  N   8  operand bit-width, signed two's complement
//  K   3  vector dimension, i.e. products per dot product; K>=1
//  CW  derived: (K>1) ? $clog2(K) : 1; width of elem_idx
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          reset, asynchronous, active-high
//  flush      in   1          synchronous abort of the current vector
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          operand pair accepted when in_valid&&in_ready
//  g_input    in   N          signed operand g
//  e_input    in   N          signed operand e
//  out_valid  out  1          dot product valid on o
//  out_ready  in   1          consumer accepts o when out_valid&&out_ready
//  o          out  2N+K-1     signed dot product, held stable while out_valid
//  elem_idx   out  CW         count of pairs accepted in the current vector (0..K-1)
//  busy       out  1          high in ACC or DONE
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, elem_idx=0, out_valid=0, busy=0, in_ready=1.
//  - FSM: IDLE -> ACC -> DONE -> IDLE.
//    IDLE: in_ready=1. On accept: acc<=product, elem_idx<=1, go to ACC. If K==1, go straight to DONE.
//    ACC: in_ready=1. On accept: acc<=acc+product, elem_idx++. The accept that completes pair K goes to DONE.
//    DONE: out_valid=1, o=acc, in_ready=out_ready.
//      On out_valid&&out_ready with no new pair: go to IDLE, elem_idx<=0.
//      On out_valid&&out_ready with a simultaneous in accept: acc<=product, elem_idx<=1, go to ACC (or stay in DONE if K==1).
//      In the second case there are no bubbles between vectors.
//  - Latency: out_valid rises on the cycle after pair K is accepted. Throughput is one pair per cycle.
//  - Arithmetic:
//    product = g_input*e_input, signed, 2N bits, sign-extended to 2N+K-1 bits.
//    The sum cannot overflow for any K>=1 since K*2^(2N-2) < 2^(2N+K-2). No saturation.
//  - in_valid while in_ready=0 is ignored. The operand source must hold its data.
//  - flush: highest priority. Next state is IDLE, acc=0, elem_idx=0, out_valid=0.
//    A pending unconsumed result is discarded. A pair presented in the flush cycle is not accepted (in_ready=0 during flush).
//  - rst mid-vector: asynchronous return to the reset values. A partial sum is never emitted.
//  - o is driven only from the acc register, with no combinational path from the inputs.
// CONFIGURATION
//  VDP_BIAS_EN defined:
//    adds port bias_in (in, 2N bits, signed), sampled only with the first pair of each vector.
//    The first accept loads acc<=sext(bias_in)+product.
//    The output widens to 2N+K bits so that the bias cannot overflow.
//  VDP_BIAS_EN undefined: no bias_in port, o is 2N+K-1 bits, behaviour exactly as above.
// TESTING (N=8, K=3, VDP_BIAS_EN undefined unless noted)
//  - Pairs (1,2),(3,4),(5,6) on consecutive cycles, out_ready=1 -> out_valid is high exactly 1 cycle after the 3rd accept, with o=44.
//  - Pairs (-128,-128) x3 -> o=49152. Pairs (-128,127) x3 -> o=-48768.
//  - Hold out_ready=0 for 5 cycles after DONE -> o=44 stays stable, in_ready=0, and in_valid pairs are not accepted.
//  - Back-to-back vectors with out_ready=1 -> the next vector's first pair is accepted in the DONE cycle, with no bubble.
//    Second vector (2,2),(2,2),(2,2) gives o=12.
//  - flush after 2 pairs, then (1,1),(1,1),(1,1) -> o=3. The prior partial sum is never output.
//    Assert rst mid-vector and check the reset values.
//  - VDP_BIAS_EN defined, bias_in=-10, pairs (1,2),(3,4),(5,6) -> o=34. A bias_in change on the 2nd/3rd pair has no effect.

Source files
------------

// File: rtl/vdp_mac_sequencer.sv
// vdp_mac_sequencer: sequences one signed MAC datapath through K-element dot products.
// Operand pairs (g,e) arrive on a valid/ready stream. Each vector accumulates exactly
// K products, and the finished sum is presented on a valid/ready output.
// Optional feature macro: VDP_BIAS_EN. It adds a bias_in port that is sampled with the
// first pair of each vector, and it widens o by one bit.
module vdp_mac_sequencer #(
    parameter int unsigned N = 8,
    parameter int unsigned K = 3,
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1,
`ifdef VDP_BIAS_EN
    localparam int unsigned OW = 2 * N + K
`else
    localparam int unsigned OW = 2 * N + K - 1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      g_input,
    input  logic [N-1:0]      e_input,
`ifdef VDP_BIAS_EN
    input  logic [2*N-1:0]    bias_in,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     o,
    output logic [CW-1:0]     elem_idx,
    output logic              busy
);

    localparam int unsigned PW = 2 * N;
    localparam bit SINGLE = (K == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [OW-1:0] acc_q, acc_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic                 out_valid_q, busy_q;

    logic signed [PW-1:0] prod;
    logic signed [OW-1:0] prod_ext;
    logic signed [OW-1:0] first_val;
    logic                 accept;

    // Full-width signed product; operands are sign-extended so no bits are lost
    assign prod     = $signed({{N{g_input[N-1]}}, g_input}) * $signed({{N{e_input[N-1]}}, e_input});
    assign prod_ext = OW'(prod);

`ifdef VDP_BIAS_EN
    // The first pair of a vector also loads the bias
    assign first_val = OW'($signed(bias_in)) + prod_ext;
`else
    assign first_val = prod_ext;
`endif

    // Ready is blocked during flush and while a result waits for the consumer
    assign in_ready = !flush && ((state_q != DONE) || out_ready);
    assign accept   = in_valid && in_ready;

    assign o         = acc_q;
    assign elem_idx  = idx_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = first_val;
                    state_d = SINGLE ? DONE : ACC;
                    idx_d   = SINGLE ? CW'(0) : CW'(1);
                end
            end
            ACC: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    if (idx_q == CW'(K - 1)) begin
                        state_d = DONE;
                        idx_d   = CW'(0);
                    end else begin
                        idx_d = idx_q + CW'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) begin
                        acc_d   = first_val;
                        state_d = SINGLE ? DONE : ACC;
                        idx_d   = SINGLE ? CW'(0) : CW'(1);
                    end else begin
                        state_d = IDLE;
                        idx_d   = CW'(0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                idx_d   = CW'(0);
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            acc_d   = '0;
            idx_d   = CW'(0);
        end
    end

    // State, accumulator and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

endmodule
